ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameters: WORD_W, 32, datapath width; ALUSEL_W, 3, unit select width; ALUOP_W, 5, sub-op width; MEMOP_W, 4, memory-op width.
REQ-002 SHALL use one clock; reset is asynchronous and active-low; ports are named clk and rst.
REQ-003 SHALL provide these ports:
- clk  in  1  rising-edge clock
- rst  in  1  async active-low reset
- ex_alusel  in  ALUSEL_W  unit select from the ID/EX register
- ex_aluop  in  ALUOP_W  sub-op
- ex_srcLeft  in  WORD_W  operand A
- ex_srcRight  in  WORD_W  operand B
- ex_memop  in  MEMOP_W  memory op, passed through
- ex_dest  in  5  destination register
- ex_writeEnable  in  1  register write request
- flush  in  1  kill the current EX instruction
- stall_req  out  1  freeze upstream stages
- mem_result  out  WORD_W  registered result
- mem_memop  out  MEMOP_W  registered memop
- mem_dest  out  5  registered destination
- mem_writeEnable  out  1  registered write enable
- hi  out  WORD_W  HI register
- lo  out  WORD_W  LO register

Function
REQ-004 SHALL decode ex_alusel as 0 NOP, 1 LOGIC, 2 SHIFT, 3 ARITH, 4 MULDIV; all other codes SHALL be treated as NOP.
REQ-005 SHALL implement LOGIC ops: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 LUI (srcRight[15:0]<<16).
REQ-006 SHALL implement SHIFT ops on srcRight, with shamt = srcLeft[4:0]: 0 SLL, 1 SRL, 2 SRA.
REQ-007 SHALL implement ARITH ops: 0 ADD, 1 SUB, 2 SLT (signed), 3 SLTU; all are modulo 2^32 with no overflow trap.
REQ-008 SHALL implement MULDIV ops: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO.
REQ-009 For MULT/MULTU, the 64-bit product SHALL be written with {hi,lo} <= product; this is single cycle.
REQ-010 MTHI/MTLO SHALL write srcLeft to hi/lo respectively; MFHI/MFLO SHALL return the current hi/lo as the result.
REQ-011 MULT, MULTU, MTHI, MTLO, DIV and DIVU SHALL force mem_writeEnable=0.
REQ-012 Any undefined sub-op SHALL produce result 0 and mem_writeEnable=0.
REQ-013 Single-cycle ops SHALL register the result, ex_memop, ex_dest and ex_writeEnable into the mem_* outputs at the next rising edge (latency 1).
REQ-014 NOP SHALL register result 0, memop 0, dest 0 and writeEnable 0.
REQ-015 DIV/DIVU SHALL use a radix-2 restoring divider FSM with states IDLE, RUN and DONE, and a 5-bit iteration counter.
REQ-016 In IDLE, when a DIV/DIVU is presented with srcRight != 0, stall_req SHALL assert combinationally and the FSM SHALL move to RUN at the next edge with operands latched.
- Signed divide operates on magnitudes.
REQ-017 RUN SHALL perform one iteration per cycle for 32 cycles and then move to DONE; stall_req SHALL stay 1 throughout RUN.
REQ-018 In DONE, stall_req SHALL be 0; at the closing edge lo SHALL be written with the quotient and hi with the remainder, and the FSM SHALL return to IDLE.
- Quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
REQ-019 A DIV/DIVU with stall_req=1 for 33 cycles SHALL occupy EX for 34 cycles in total.
REQ-020 Upstream SHALL hold all ex_* inputs stable while stall_req=1; the block SHALL NOT re-latch operands during RUN.
REQ-021 While in RUN, the mem_* outputs SHALL register a bubble (all zero) each edge.
REQ-022 A divide by zero SHALL complete in 1 cycle with hi/lo unchanged, no stall, and mem_writeEnable=0.
REQ-023 flush=1 SHALL make the next registered mem_* a bubble and suppress any hi/lo write in that cycle.
REQ-024 If flush=1 occurs in RUN or DONE, the FSM SHALL abort to IDLE, hi/lo SHALL be unchanged, and stall_req SHALL deassert next cycle.
REQ-025 When hi/lo are written and read by consecutive instructions, the second instruction SHALL see the new value (write-then-read ordering).

Reset
REQ-026 rst=0 SHALL immediately clear mem_result, mem_memop, mem_dest, mem_writeEnable, hi, lo and the counter, and SHALL force the FSM to IDLE.
REQ-027 stall_req SHALL be 0 while rst=0.
REQ-028 Assertion of rst=0 during RUN SHALL abandon the divide with no hi/lo update.

Verification
REQ-029 SHALL cover: LOGIC OR, srcLeft=0x0000FF00, srcRight=0x00F0000F, dest=3, we=1 -> next edge mem_result=0x00F0FF0F, mem_dest=3, mem_writeEnable=1.
REQ-030 SHALL cover: SHIFT SRA, srcLeft=4, srcRight=0x80000000 -> mem_result=0xF8000000.
REQ-031 SHALL cover: MULT of 0xFFFFFFFE by 3, then MFLO -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; the MFLO result is 0xFFFFFFFA.
REQ-032 SHALL cover: DIV of -7 by 2 -> stall_req high for exactly 33 cycles, then lo=0xFFFFFFFD and hi=0xFFFFFFFF, with bubbles on mem_* during RUN.
REQ-033 SHALL cover: DIVU of 10 by 0 -> no stall, hi/lo unchanged; separately, flush in RUN cycle 10 -> IDLE next edge, stall_req=0, hi/lo unchanged.
REQ-034 SHALL cover: rst=0 pulsed mid-RUN, between clock edges -> all outputs 0 immediately and stall_req=0.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: logic/shift/arith units, single-cycle multiply, HI/LO registers,
// and a multi-cycle restoring divider that stalls upstream while it iterates.
module ex_stage #(
   parameter int WORD_W   = 32,
   parameter int ALUSEL_W = 3,
   parameter int ALUOP_W  = 5,
   parameter int MEMOP_W  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ALUSEL_W-1:0] ex_alusel,
   input  logic [ALUOP_W-1:0]  ex_aluop,
   input  logic [WORD_W-1:0]   ex_srcLeft,
   input  logic [WORD_W-1:0]   ex_srcRight,
   input  logic [MEMOP_W-1:0]  ex_memop,
   input  logic [4:0]          ex_dest,
   input  logic                ex_writeEnable,
   input  logic                flush,
   output logic                stall_req,
   output logic [WORD_W-1:0]   mem_result,
   output logic [MEMOP_W-1:0]  mem_memop,
   output logic [4:0]          mem_dest,
   output logic                mem_writeEnable,
   output logic [WORD_W-1:0]   hi,
   output logic [WORD_W-1:0]   lo
);

   // state | meaning
   // IDLE  | single-cycle ops execute; a DIV/DIVU with nonzero divisor starts here
   // RUN   | one restoring-divide iteration per cycle, upstream stalled
   // DONE  | quotient/remainder sign-corrected and written to lo/hi at the closing edge
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state, state_nxt;
   logic [4:0]          cnt;
   logic [WORD_W-1:0]   quo, rem, dvs;
   logic                neg_q, neg_r;

   logic [WORD_W-1:0]   res, hi_nxt, lo_nxt;
   logic [2*WORD_W-1:0] prod;
   logic                we_ok, pass, div_req, div_signed;
   logic                start, bubble;
   logic [4:0]          shamt;
   logic [WORD_W:0]     rem_sh, diff;
   logic [WORD_W-1:0]   a_mag, b_mag, quo_fix, rem_fix;

   assign shamt = ex_srcLeft[4:0];

   always_comb begin
      res        = '0;
      we_ok      = 1'b0;
      pass       = 1'b1;
      div_req    = 1'b0;
      div_signed = 1'b0;
      hi_nxt     = hi;
      lo_nxt     = lo;
      prod       = '0;
      case (int'(ex_alusel))
         1: begin
            we_ok = 1'b1;
            case (int'(ex_aluop))
               0:       res = ex_srcLeft & ex_srcRight;
               1:       res = ex_srcLeft | ex_srcRight;
               2:       res = ex_srcLeft ^ ex_srcRight;
               3:       res = ~(ex_srcLeft | ex_srcRight);
               4:       res = ex_srcRight << 16;
               default: we_ok = 1'b0;
            endcase
         end
         2: begin
            we_ok = 1'b1;
            case (int'(ex_aluop))
               0:       res = ex_srcRight << shamt;
               1:       res = ex_srcRight >> shamt;
               2:       res = $signed(ex_srcRight) >>> shamt;
               default: we_ok = 1'b0;
            endcase
         end
         3: begin
            we_ok = 1'b1;
            case (int'(ex_aluop))
               0:       res = ex_srcLeft + ex_srcRight;
               1:       res = ex_srcLeft - ex_srcRight;
               2:       res = {{(WORD_W-1){1'b0}}, $signed(ex_srcLeft) < $signed(ex_srcRight)};
               3:       res = {{(WORD_W-1){1'b0}}, ex_srcLeft < ex_srcRight};
               default: we_ok = 1'b0;
            endcase
         end
         4: begin
            case (int'(ex_aluop))
               0: begin
                  prod = $signed({{WORD_W{ex_srcLeft[WORD_W-1]}}, ex_srcLeft}) *
                         $signed({{WORD_W{ex_srcRight[WORD_W-1]}}, ex_srcRight});
                  {hi_nxt, lo_nxt} = prod;
               end
               1: begin
                  prod = {{WORD_W{1'b0}}, ex_srcLeft} * {{WORD_W{1'b0}}, ex_srcRight};
                  {hi_nxt, lo_nxt} = prod;
               end
               2: begin
                  div_req    = 1'b1;
                  div_signed = 1'b1;
               end
               3:       div_req = 1'b1;
               4: begin
                  res   = hi;
                  we_ok = 1'b1;
               end
               5: begin
                  res   = lo;
                  we_ok = 1'b1;
               end
               6:       hi_nxt = ex_srcLeft;
               7:       lo_nxt = ex_srcLeft;
               default: we_ok = 1'b0;
            endcase
         end
         default: pass = 1'b0;
      endcase
   end

   // A zero divisor never starts the divider; it retires as a one-cycle no-write op.
   assign start     = (state == IDLE) && div_req && (ex_srcRight != '0) && !flush;
   assign bubble    = flush || (state == RUN) || start;
   assign stall_req = rst && ((state == RUN) || start);

   assign a_mag   = (div_signed && ex_srcLeft[WORD_W-1])  ? -ex_srcLeft  : ex_srcLeft;
   assign b_mag   = (div_signed && ex_srcRight[WORD_W-1]) ? -ex_srcRight : ex_srcRight;
   assign rem_sh  = {rem, quo[WORD_W-1]};
   assign diff    = rem_sh - {1'b0, dvs};
   assign quo_fix = neg_q ? -quo : quo;
   assign rem_fix = neg_r ? -rem : rem;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN: begin
            if (flush)            state_nxt = IDLE;
            else if (cnt == 5'd0) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_result      <= '0;
         mem_memop       <= '0;
         mem_dest        <= '0;
         mem_writeEnable <= 1'b0;
         hi              <= '0;
         lo              <= '0;
         cnt             <= '0;
         quo             <= '0;
         rem             <= '0;
         dvs             <= '0;
         neg_q           <= 1'b0;
         neg_r           <= 1'b0;
      end else begin
         if (bubble) begin
            mem_result      <= '0;
            mem_memop       <= '0;
            mem_dest        <= '0;
            mem_writeEnable <= 1'b0;
         end else begin
            mem_result      <= res;
            mem_memop       <= pass ? ex_memop : '0;
            mem_dest        <= pass ? ex_dest : '0;
            mem_writeEnable <= pass && we_ok && ex_writeEnable;
         end
         if (!flush) begin
            if (state == DONE) begin
               hi <= rem_fix;
               lo <= quo_fix;
            end else if (state == IDLE) begin
               hi <= hi_nxt;
               lo <= lo_nxt;
            end
         end
         if (start) begin
            quo   <= a_mag;
            dvs   <= b_mag;
            rem   <= '0;
            neg_q <= div_signed && (ex_srcLeft[WORD_W-1] ^ ex_srcRight[WORD_W-1]);
            neg_r <= div_signed && ex_srcLeft[WORD_W-1];
            cnt   <= 5'(WORD_W-1);
         end else if (state == RUN) begin
            cnt <= cnt - 5'd1;
            if (!diff[WORD_W]) begin
               rem <= diff[WORD_W-1:0];
               quo <= {quo[WORD_W-2:0], 1'b1};
            end else begin
               rem <= rem_sh[WORD_W-1:0];
               quo <= {quo[WORD_W-2:0], 1'b0};
            end
         end
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: a cycle-level reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  ex_alusel = '0;
   logic [4:0]  ex_aluop = '0;
   logic [31:0] ex_srcLeft = '0, ex_srcRight = '0;
   logic [3:0]  ex_memop = '0;
   logic [4:0]  ex_dest = '0;
   logic        ex_writeEnable = 1'b0;
   logic        flush = 1'b0;
   logic        stall_req;
   logic [31:0] mem_result, hi, lo;
   logic [3:0]  mem_memop;
   logic [4:0]  mem_dest;
   logic        mem_writeEnable;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   ex_stage dut (
      .clk(clk), .rst(rst),
      .ex_alusel(ex_alusel), .ex_aluop(ex_aluop),
      .ex_srcLeft(ex_srcLeft), .ex_srcRight(ex_srcRight),
      .ex_memop(ex_memop), .ex_dest(ex_dest), .ex_writeEnable(ex_writeEnable),
      .flush(flush), .stall_req(stall_req),
      .mem_result(mem_result), .mem_memop(mem_memop), .mem_dest(mem_dest),
      .mem_writeEnable(mem_writeEnable), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model. occ counts edges since a divide was accepted; the divide
   // stalls for 33 cycles and retires on its 34th.
   int          occ = 0;
   logic [31:0] m_res = '0, m_hi = '0, m_lo = '0, d_a = '0, d_b = '0, r = '0;
   logic [3:0]  m_memop = '0;
   logic [4:0]  m_dest = '0;
   logic        m_we = 1'b0, d_sgn = 1'b0, ok = 1'b0;
   logic [63:0] p = '0;

   function automatic logic div_start();
      return ex_alusel == 3'd4 && (ex_aluop == 5'd2 || ex_aluop == 5'd3) &&
             ex_srcRight != 32'd0 && !flush;
   endfunction

   function automatic logic exp_stall();
      return rst && ((occ >= 1 && occ <= 32) || (occ == 0 && div_start()));
   endfunction

   task automatic m_bubble();
      m_res = '0; m_memop = '0; m_dest = '0; m_we = 1'b0;
   endtask

   task automatic m_op();
      r = '0; ok = 1'b0;
      case (ex_alusel)
         3'd1: begin
            ok = 1'b1;
            case (ex_aluop)
               5'd0: r = ex_srcLeft & ex_srcRight;
               5'd1: r = ex_srcLeft | ex_srcRight;
               5'd2: r = ex_srcLeft ^ ex_srcRight;
               5'd3: r = ~(ex_srcLeft | ex_srcRight);
               5'd4: r = {ex_srcRight[15:0], 16'h0000};
               default: ok = 1'b0;
            endcase
         end
         3'd2: begin
            ok = 1'b1;
            case (ex_aluop)
               5'd0: r = ex_srcRight << ex_srcLeft[4:0];
               5'd1: r = ex_srcRight >> ex_srcLeft[4:0];
               5'd2: r = $signed(ex_srcRight) >>> ex_srcLeft[4:0];
               default: ok = 1'b0;
            endcase
         end
         3'd3: begin
            ok = 1'b1;
            case (ex_aluop)
               5'd0: r = ex_srcLeft + ex_srcRight;
               5'd1: r = ex_srcLeft - ex_srcRight;
               5'd2: r = ($signed(ex_srcLeft) < $signed(ex_srcRight)) ? 32'd1 : 32'd0;
               5'd3: r = (ex_srcLeft < ex_srcRight) ? 32'd1 : 32'd0;
               default: ok = 1'b0;
            endcase
         end
         3'd4: begin
            case (ex_aluop)
               5'd0: begin
                  p = 64'($signed(ex_srcLeft)) * 64'($signed(ex_srcRight));
                  m_hi = p[63:32]; m_lo = p[31:0];
               end
               5'd1: begin
                  p = {32'd0, ex_srcLeft} * {32'd0, ex_srcRight};
                  m_hi = p[63:32]; m_lo = p[31:0];
               end
               5'd4: begin r = m_hi; ok = 1'b1; end
               5'd5: begin r = m_lo; ok = 1'b1; end
               5'd6: m_hi = ex_srcLeft;
               5'd7: m_lo = ex_srcLeft;
               default: ok = 1'b0;
            endcase
         end
         default: ;
      endcase
      if (ex_alusel == 3'd0 || ex_alusel > 3'd4) m_bubble();
      else begin
         m_res = r; m_memop = ex_memop; m_dest = ex_dest; m_we = ex_writeEnable && ok;
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_bubble(); m_hi = '0; m_lo = '0; occ = 0;
      end else if (occ == 0 && div_start()) begin
         occ = 1; d_a = ex_srcLeft; d_b = ex_srcRight; d_sgn = (ex_aluop == 5'd2);
         m_bubble();
      end else if (occ >= 1 && occ <= 32) begin
         occ = flush ? 0 : occ + 1;
         m_bubble();
      end else if (occ == 33) begin
         occ = 0;
         if (flush) m_bubble();
         else begin
            if (d_sgn) begin
               m_lo = $signed(d_a) / $signed(d_b);
               m_hi = $signed(d_a) % $signed(d_b);
            end else begin
               m_lo = d_a / d_b;
               m_hi = d_a % d_b;
            end
            m_res = '0; m_memop = ex_memop; m_dest = ex_dest; m_we = 1'b0;
         end
      end else if (flush) m_bubble();
      else m_op();
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("mdl_mem_result", mem_result, m_res);
         check("mdl_mem_memop", mem_memop, m_memop);
         check("mdl_mem_dest", mem_dest, m_dest);
         check("mdl_mem_we", mem_writeEnable, m_we);
         check("mdl_hi", hi, m_hi);
         check("mdl_lo", lo, m_lo);
         check("mdl_stall", stall_req, exp_stall());
      end
   end

   task automatic set_in(input logic [2:0] sel, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] mo, input logic [4:0] d,
                         input logic we, input logic fl);
      ex_alusel = sel; ex_aluop = op; ex_srcLeft = a; ex_srcRight = b;
      ex_memop = mo; ex_dest = d; ex_writeEnable = we; flush = fl;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   typedef struct {
      logic [2:0]  sel;
      logic [4:0]  op;
      logic [31:0] a, b, res;
      logic        we;
   } vec_t;

   vec_t vecs[14] = '{
      '{3'd1, 5'd1, 32'h0000FF00, 32'h00F0000F, 32'h00F0FF0F, 1'b1},
      '{3'd2, 5'd2, 32'd4,        32'h80000000, 32'hF8000000, 1'b1},
      '{3'd1, 5'd0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b1},
      '{3'd1, 5'd2, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b1},
      '{3'd1, 5'd3, 32'h00000000, 32'h0000FFFF, 32'hFFFF0000, 1'b1},
      '{3'd1, 5'd4, 32'h0,        32'h00001234, 32'h12340000, 1'b1},
      '{3'd2, 5'd0, 32'd8,        32'h00000081, 32'h00008100, 1'b1},
      '{3'd2, 5'd1, 32'd4,        32'h80000000, 32'h08000000, 1'b1},
      '{3'd3, 5'd0, 32'hFFFFFFFF, 32'd2,        32'h00000001, 1'b1},
      '{3'd3, 5'd1, 32'd1,        32'd2,        32'hFFFFFFFF, 1'b1},
      '{3'd3, 5'd2, 32'hFFFFFFFF, 32'd1,        32'h00000001, 1'b1},
      '{3'd3, 5'd3, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b1},
      '{3'd1, 5'd7, 32'h12345678, 32'h1,        32'h00000000, 1'b0},
      '{3'd6, 5'd0, 32'h12345678, 32'h1,        32'h00000000, 1'b0}
   };

   initial begin
      int n;
      repeat (2) @(posedge clk);
      #2;
      check("rst_mem_result", mem_result, 0);
      check("rst_mem_we", mem_writeEnable, 0);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_stall", stall_req, 0);
      rst = 1'b1;
      chk_en = 1'b1;
      step();

      for (int i = 0; i < 14; i++) begin
         set_in(vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b, 4'(i), 5'(i + 3), 1'b1, 1'b0);
         step();
         check($sformatf("vec%0d_result", i), mem_result, vecs[i].res);
         check($sformatf("vec%0d_we", i), mem_writeEnable, vecs[i].we);
         if (i == 0) check("or_dest", mem_dest, 3);
      end

      set_in(3'd4, 5'd0, 32'hFFFFFFFE, 32'd3, 4'd0, 5'd7, 1'b1, 1'b0);
      step();
      check("mult_hi", hi, 32'hFFFFFFFF);
      check("mult_lo", lo, 32'hFFFFFFFA);
      check("mult_we", mem_writeEnable, 0);
      set_in(3'd4, 5'd5, 32'd0, 32'd0, 4'd0, 5'd8, 1'b1, 1'b0);
      step();
      check("mflo_result", mem_result, 32'hFFFFFFFA);
      check("mflo_we", mem_writeEnable, 1);

      set_in(3'd4, 5'd6, 32'h0000DEAD, 32'd0, 4'd1, 5'd9, 1'b1, 1'b1);
      step();
      check("flush_mthi_hi", hi, 32'hFFFFFFFF);
      check("flush_dest", mem_dest, 0);

      set_in(3'd4, 5'd2, 32'hFFFFFFF9, 32'd2, 4'd3, 5'd5, 1'b1, 1'b0);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (i == 5) check("run_bubble_dest", mem_dest, 0);
         if (stall_req) n++;
         else break;
      end
      check("div_stall_cycles", n, 33);
      step();
      check("div_lo", lo, 32'hFFFFFFFD);
      check("div_hi", hi, 32'hFFFFFFFF);
      check("div_we", mem_writeEnable, 0);

      set_in(3'd4, 5'd6, 32'h00001234, 32'd0, 4'd0, 5'd1, 1'b0, 1'b0);
      step();
      set_in(3'd4, 5'd7, 32'h00005678, 32'd0, 4'd0, 5'd1, 1'b0, 1'b0);
      step();
      set_in(3'd4, 5'd3, 32'd10, 32'd0, 4'd2, 5'd4, 1'b1, 1'b0);
      #1;
      check("div0_stall", stall_req, 0);
      step();
      check("div0_hi", hi, 32'h00001234);
      check("div0_lo", lo, 32'h00005678);
      check("div0_we", mem_writeEnable, 0);

      set_in(3'd4, 5'd3, 32'd100, 32'd7, 4'd2, 5'd4, 1'b1, 1'b0);
      step();
      repeat (9) step();
      flush = 1'b1;
      step();
      set_in(3'd0, 5'd0, 32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0);
      #1;
      check("flush_run_stall", stall_req, 0);
      check("flush_run_hi", hi, 32'h00001234);
      check("flush_run_lo", lo, 32'h00005678);
      step();

      set_in(3'd4, 5'd3, 32'd100, 32'd7, 4'd2, 5'd4, 1'b1, 1'b0);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (stall_req) n++;
         else break;
      end
      check("divu_stall_cycles", n, 33);
      step();
      check("divu_lo", lo, 32'd14);
      check("divu_hi", hi, 32'd2);
      set_in(3'd0, 5'd0, 32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0);
      step();

      set_in(3'd4, 5'd2, 32'd1000, 32'd3, 4'd5, 5'd6, 1'b1, 1'b0);
      repeat (3) step();
      #1 rst = 1'b0;
      #1;
      check("rstrun_result", mem_result, 0);
      check("rstrun_memop", mem_memop, 0);
      check("rstrun_dest", mem_dest, 0);
      check("rstrun_we", mem_writeEnable, 0);
      check("rstrun_hi", hi, 0);
      check("rstrun_lo", lo, 0);
      check("rstrun_stall", stall_req, 0);
      @(posedge clk);
      #2;
      set_in(3'd0, 5'd0, 32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      set_in(3'd4, 5'd5, 32'd0, 32'd0, 4'd0, 5'd2, 1'b1, 1'b0);
      step();
      check("post_rst_mflo", mem_result, 0);
      check("post_rst_mflo_we", mem_writeEnable, 1);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
